wac_cmd_hub: RTL and testbench
==============================

// Module: wac_cmd_hub
// PURPOSE
//  Parametrised command dispatcher for the WAC board. Decodes ctrl_word/conf_word on a cmd_stb pulse and
//  starts one peripheral controller (DAC, digipot, sequencer, ADC channel k of N_ADC), or updates the MUX
//  register. Tracks busy/done/timeout per command. Gathers ADC samples from all channels onto a single
//  ready/valid stream, using one holding register per channel and round-robin arbitration.
// PARAMETERS
//  N_ADC    2      number of ADC controllers, 1..16
//  ADC_W    12     ADC sample width
//  NS_W     12     width of the sample-count field
//  CONF_W   16     width of conf_word (must be >= 16)
//  N_MUX    4      number of MUX/REF enable bits (must be <= CONF_W)
//  TO_W     16     timeout counter width; timeout = 2**TO_W-1 cycles
// PORTS
//  clk          in   1                clock; all logic is on the rising edge
//  rst_n        in   1                asynchronous, active-low reset
//  cmd_stb      in   1                1-cycle command strobe; ignored while cmd_busy=1
//  ctrl_word    in   8                [3:0] opcode, [7:4] channel or mode field
//  conf_word    in   CONF_W           command payload
//  n_samples    in   NS_W             ADC sample count
//  adc_mode     in   1                ADC mode: 0 = single, 1 = burst
//  cmd_busy     out  1                a command is in flight
//  cmd_done     out  1                1-cycle pulse when a command ends
//  cmd_err      out  2                status valid with cmd_done: 0 ok, 1 bad opcode, 2 bad channel, 3 timeout
//  mux_cfg      out  N_MUX            MUX/REF enable register
//  dac_start    out  1                1-cycle start pulse to the DAC controller
//  dac_data     out  16               DAC payload
//  dac_done     in   1                DAC controller done
//  dpot_start   out  1                1-cycle start pulse to the digipot controller
//  dpot_sel     out  2                digipot select
//  dpot_data    out  8                digipot payload
//  dpot_done    in   1                digipot controller done
//  seq_start    out  1                1-cycle start pulse to the sequencer
//  seq_mode     out  2                sequencer mode
//  seq_done     in   1                sequencer done
//  adc_start    out  N_ADC            one-hot start pulse, one bit per ADC channel
//  adc_mode_o   out  1                ADC mode passed to the channel
//  adc_n        out  NS_W             sample count passed to the channel
//  adc_dat_i    in   N_ADC*ADC_W      packed samples; channel k at [k*ADC_W +: ADC_W]
//  adc_vld_i    in   N_ADC            per-channel sample-valid pulse
//  adc_done_i   in   N_ADC            per-channel capture done
//  out_data     out  ADC_W            output stream sample
//  out_ch       out  4                output stream channel index
//  out_valid    out  1                output stream valid
//  out_ready    in   1                output stream ready
//  ovf          out  N_ADC            sticky per-channel overrun flag
// BEHAVIOUR
//  Reset values:
//   - every output is 0, except mux_cfg = all 1s and dpot_sel = 2'b11.
//   - FSM is in IDLE; all holding registers are empty; the arbiter pointer is 0.
//  FSM states: IDLE -> ISSUE -> WAIT -> FIN -> IDLE.
//  IDLE:
//   - On cmd_stb, latch ctrl_word, conf_word, n_samples and adc_mode; raise cmd_busy; go to ISSUE.
//  ISSUE (exactly 1 cycle) acts on the latched opcode:
//   - 1 DAC: dac_data = conf[15:0]; pulse dac_start; go to WAIT.
//   - 2 MUX: mux_cfg = conf[N_MUX-1:0]; go to FIN with err 0. There is no peripheral wait.
//   - 3 DPOT: dpot_sel = conf[9:8]; dpot_data = conf[7:0]; pulse dpot_start; go to WAIT.
//   - 4 SEQ: seq_mode = ctrl[5:4]; pulse seq_start; go to WAIT.
//   - 9 ADC: ch = ctrl[7:4]. If ch >= N_ADC, go to FIN with err 2. Otherwise pulse adc_start[ch],
//     drive adc_mode_o and adc_n; go to WAIT.
//   - Any other opcode: go to FIN with err 1.
//   - dac_data, dpot_*, seq_mode, adc_mode_o and adc_n hold their values until the next command.
//  WAIT:
//   - Wait for the done input of the addressed target. Only the addressed done input is looked at.
//   - A 1-cycle done is enough; a done already high in the ISSUE cycle is not accepted.
//   - A TO_W-bit counter is cleared in ISSUE and counts up in WAIT. At all-ones, go to FIN with err 3.
//  FIN (1 cycle):
//   - cmd_done = 1 and cmd_err is valid for this cycle only.
//   - cmd_busy drops in the following cycle.
//   - A cmd_stb in the FIN cycle is ignored.
//  Latency:
//   - MUX command: cmd_stb at cycle t gives mux_cfg updated at t+2 and cmd_done at t+2.
//   - Waited command: the start pulse is at t+1; cmd_done is 1 cycle after the done input is seen.
//  Sample path:
//   - Each channel has 1 holding register plus a full flag.
//   - adc_vld_i[k] loads hold[k] when it is empty, or when it is being drained in the same cycle.
//   - adc_vld_i[k] while hold[k] is full and not draining: sample dropped and ovf[k] is set.
//     ovf clears only on reset.
//   - Arbiter: round-robin over the full registers, starting at the pointer. The granted channel drives
//     out_data and out_ch, registered.
//   - out_valid stays asserted and the data stays stable until out_ready. On the handshake, the pointer
//     moves to grant+1, modulo N_ADC.
//   - With N_ADC = 1 the arbiter degenerates to the single channel.
//   - The sample path runs independently of the command FSM.
//  Reset mid-operation: everything returns to the reset values immediately. Outstanding peripheral
//  activity is not tracked.
// STRUCTURE
//  Shared package wac_pkg:
//   - opcode constants OP_DAC=4'h1, OP_MUX=4'h2, OP_DPOT=4'h3, OP_SEQ=4'h4, OP_ADC=4'h9
//   - error codes ERR_OK, ERR_OPC, ERR_CH, ERR_TO
//   - FSM state encoding
//  Sub-module wac_rr_arb (N parameter): request vector + pointer in, one-hot grant + index out.
//  The command FSM, timeout counter and holding registers stay in this module.
// TESTING
//  1. Reset: mux_cfg=4'hF, dpot_sel=2'b11, out_valid=0, cmd_busy=0.
//  2. cmd_stb with ctrl=8'h02, conf=16'h0005: mux_cfg=4'h5 at t+2; cmd_done at t+2 with err 0;
//     no start pulses.
//  3. cmd_stb with ctrl=8'h19 (ADC ch1), n=100: adc_start=2'b10 for 1 cycle and adc_n=100;
//     adc_done_i[1] 20 cycles later gives cmd_done 1 cycle after, err 0. A done on ch0 is ignored.
//  4. ctrl=8'h29 with N_ADC=2 gives err 2; ctrl=8'h07 gives err 1; DAC with no dac_done gives err 3
//     after 65535 WAIT cycles. A cmd_stb while busy is dropped.
//  5. Both channels assert valid in the same cycle with out_ready=1: ch0 comes out then ch1, in
//     alternation. Hold out_ready=0 for 3 samples: ovf sets and out_data stays stable.
//  6. Deassert rst_n in the middle of WAIT: all outputs return to the reset values; a fresh command
//     then completes normally.

Source files
------------

// File: rtl/wac_pkg.sv
// wac_pkg: shared opcodes, error codes and command FSM states for the WAC command hub
package wac_pkg;
  localparam logic [3:0] OP_DAC  = 4'h1;
  localparam logic [3:0] OP_MUX  = 4'h2;
  localparam logic [3:0] OP_DPOT = 4'h3;
  localparam logic [3:0] OP_SEQ  = 4'h4;
  localparam logic [3:0] OP_ADC  = 4'h9;
  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_OPC = 2'd1;
  localparam logic [1:0] ERR_CH  = 2'd2;
  localparam logic [1:0] ERR_TO  = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FIN} state_t;
endpackage

// File: rtl/wac_cmd_hub_if.sv
// wac_cmd_hub_if: ready/valid stream carrying gathered ADC samples and their channel index
interface wac_cmd_hub_if #(parameter int ADC_W = 12);
  logic [ADC_W-1:0] out_data;
  logic [3:0]       out_ch;
  logic             out_valid;
  logic             out_ready;
  modport master (output out_data, out_ch, out_valid, input out_ready);
  modport slave  (input out_data, out_ch, out_valid, output out_ready);
endinterface

// File: rtl/wac_rr_arb.sv
// wac_rr_arb: round-robin arbiter, first request at or after ptr wins
module wac_rr_arb #(parameter int N = 2) (
  input  logic [N-1:0] req,
  input  logic [3:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [3:0]   idx
);
  logic [N-1:0] rot;
  // rotate requests so ptr sits at bit 0, pick the lowest set bit, rotate back
  always_comb begin
    int off;
    off = 0;
    rot = N'({req, req} >> ptr);
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = i;
    idx = 4'((int'(ptr) + off) % N);
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/wac_cmd_hub.sv
// wac_cmd_hub: command dispatcher for WAC peripherals plus round-robin ADC sample gatherer
module wac_cmd_hub import wac_pkg::*; #(
  parameter int N_ADC  = 2,
  parameter int ADC_W  = 12,
  parameter int NS_W   = 12,
  parameter int CONF_W = 16,
  parameter int N_MUX  = 4,
  parameter int TO_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_stb,
  input  logic [7:0]             ctrl_word,
  input  logic [CONF_W-1:0]      conf_word,
  input  logic [NS_W-1:0]        n_samples,
  input  logic                   adc_mode,
  output logic                   cmd_busy,
  output logic                   cmd_done,
  output logic [1:0]             cmd_err,
  output logic [N_MUX-1:0]       mux_cfg,
  output logic                   dac_start,
  output logic [15:0]            dac_data,
  input  logic                   dac_done,
  output logic                   dpot_start,
  output logic [1:0]             dpot_sel,
  output logic [7:0]             dpot_data,
  input  logic                   dpot_done,
  output logic                   seq_start,
  output logic [1:0]             seq_mode,
  input  logic                   seq_done,
  output logic [N_ADC-1:0]       adc_start,
  output logic                   adc_mode_o,
  output logic [NS_W-1:0]        adc_n,
  input  logic [N_ADC*ADC_W-1:0] adc_dat_i,
  input  logic [N_ADC-1:0]       adc_vld_i,
  input  logic [N_ADC-1:0]       adc_done_i,
  output logic [N_ADC-1:0]       ovf,
  wac_cmd_hub_if.master          so
);
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  state_t state, state_d;
  logic [7:0] ctrl_q;
  logic [N_MUX-1:0] mux_q;
  logic [1:0] err_q, err_d;
  logic [TO_W-1:0] cnt;
  logic [3:0] opc, ch;
  logic [N_ADC-1:0] ch_oh;
  logic issue, done_sel, take;
  assign opc = ctrl_q[3:0];
  assign ch = ctrl_q[7:4];
  assign ch_oh = N_ADC'(1) << ch;
  assign issue = state == ST_ISSUE;
  assign take = state == ST_IDLE && cmd_stb;
  assign done_sel = opc == OP_DAC ? dac_done : opc == OP_DPOT ? dpot_done :
                    opc == OP_SEQ ? seq_done : |(adc_done_i & ch_oh);
  assign cmd_busy = state != ST_IDLE;
  assign cmd_done = state == ST_FIN;
  assign cmd_err = cmd_done ? err_q : ERR_OK;
  assign dac_start = issue && opc == OP_DAC;
  assign dpot_start = issue && opc == OP_DPOT;
  assign seq_start = issue && opc == OP_SEQ;
  assign adc_start = issue && opc == OP_ADC ? ch_oh : '0;
  // command state, status and timeout counter (cleared in ISSUE, runs in WAIT)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      err_q <= ERR_OK;
      cnt <= '0;
    end else begin
      state <= state_d;
      err_q <= err_d;
      cnt <= issue ? '0 : state == ST_WAIT ? cnt + 1'b1 : cnt;
    end
  end
  // next state; timeout fires when the counter is about to reach all-ones
  always_comb begin
    state_d = state;
    err_d = err_q;
    case (state)
      ST_IDLE: state_d = cmd_stb ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        err_d = ERR_OK;
        if (opc == OP_DAC || opc == OP_DPOT || opc == OP_SEQ) state_d = ST_WAIT;
        else if (opc == OP_ADC) begin
          state_d = |ch_oh ? ST_WAIT : ST_FIN;
          err_d = |ch_oh ? ERR_OK : ERR_CH;
        end else begin
          state_d = ST_FIN;
          err_d = opc == OP_MUX ? ERR_OK : ERR_OPC;
        end
      end
      ST_WAIT: begin
        state_d = done_sel || cnt == TO_LAST ? ST_FIN : ST_WAIT;
        err_d = done_sel ? ERR_OK : ERR_TO;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // latch the command and peripheral payloads so they are valid alongside the start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      mux_q <= '0;
      mux_cfg <= '1;
      dac_data <= '0;
      dpot_sel <= 2'b11;
      dpot_data <= '0;
      seq_mode <= '0;
      adc_mode_o <= 1'b0;
      adc_n <= '0;
    end else begin
      if (take) begin
        ctrl_q <= ctrl_word;
        mux_q <= conf_word[N_MUX-1:0];
        if (ctrl_word[3:0] == OP_DAC) dac_data <= conf_word[15:0];
        if (ctrl_word[3:0] == OP_DPOT) {dpot_sel, dpot_data} <= conf_word[9:0];
        if (ctrl_word[3:0] == OP_SEQ) seq_mode <= ctrl_word[5:4];
        if (ctrl_word[3:0] == OP_ADC) {adc_mode_o, adc_n} <= {adc_mode, n_samples};
      end
      if (issue && opc == OP_MUX) mux_cfg <= mux_q;
    end
  end
  logic [ADC_W-1:0] hold [N_ADC];
  logic [ADC_W-1:0] sel_data;
  logic [N_ADC-1:0] full, gnt, drain;
  logic [3:0] idx, ptr, ptr_eff;
  logic hs, load;
  assign hs = so.out_valid && so.out_ready;
  assign load = |full && (!so.out_valid || so.out_ready);
  assign drain = load ? gnt : '0;
  assign ptr_eff = hs ? (so.out_ch == 4'(N_ADC - 1) ? 4'd0 : so.out_ch + 4'd1) : ptr;
  wac_rr_arb #(.N(N_ADC)) u_arb (.req(full), .ptr(ptr_eff), .gnt(gnt), .idx(idx));
  // granted holding register feeds the output register
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_ADC; k++) if (gnt[k]) sel_data = hold[k];
  end
  // per-channel holding registers; a sample arriving while full and not draining is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      ovf <= '0;
      for (int k = 0; k < N_ADC; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < N_ADC; k++) begin
        if (adc_vld_i[k] && (!full[k] || drain[k])) begin
          hold[k] <= adc_dat_i[k*ADC_W +: ADC_W];
          full[k] <= 1'b1;
        end else if (drain[k]) full[k] <= 1'b0;
        if (adc_vld_i[k] && full[k] && !drain[k]) ovf[k] <= 1'b1;
      end
    end
  end
  // output register holds until accepted; the pointer advances past the accepted channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      so.out_data <= '0;
      so.out_ch <= '0;
      so.out_valid <= 1'b0;
      ptr <= '0;
    end else begin
      if (load) begin
        so.out_data <= sel_data;
        so.out_ch <= idx;
        so.out_valid <= 1'b1;
      end else if (hs) so.out_valid <= 1'b0;
      if (hs) ptr <= ptr_eff;
    end
  end
endmodule

// File: tb/tb_wac_cmd_hub.sv
// tb_wac_cmd_hub: directed self-checking bench for wac_cmd_hub (N_ADC=2, TO_W=16)
module tb_wac_cmd_hub;
  logic clk = 1'b0, rst_n = 1'b1, cmd_stb = 1'b0, adc_mode = 1'b0;
  logic [7:0] ctrl_word = '0;
  logic [15:0] conf_word = '0;
  logic [11:0] n_samples = '0;
  logic cmd_busy, cmd_done, dac_start, dpot_start, seq_start, adc_mode_o;
  logic [1:0] cmd_err, dpot_sel, seq_mode, adc_start, ovf;
  logic [3:0] mux_cfg;
  logic [15:0] dac_data;
  logic [7:0] dpot_data;
  logic [11:0] adc_n;
  logic dac_done = 1'b0, dpot_done = 1'b0, seq_done = 1'b0;
  logic [23:0] adc_dat_i = '0;
  logic [1:0] adc_vld_i = '0, adc_done_i = '0;
  int checks = 0, failures = 0, n = 0;
  always #5 clk = ~clk;
  wac_cmd_hub_if #(.ADC_W(12)) sif ();
  wac_cmd_hub dut (
    .clk(clk), .rst_n(rst_n), .cmd_stb(cmd_stb), .ctrl_word(ctrl_word), .conf_word(conf_word),
    .n_samples(n_samples), .adc_mode(adc_mode), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .cmd_err(cmd_err), .mux_cfg(mux_cfg), .dac_start(dac_start), .dac_data(dac_data),
    .dac_done(dac_done), .dpot_start(dpot_start), .dpot_sel(dpot_sel), .dpot_data(dpot_data),
    .dpot_done(dpot_done), .seq_start(seq_start), .seq_mode(seq_mode), .seq_done(seq_done),
    .adc_start(adc_start), .adc_mode_o(adc_mode_o), .adc_n(adc_n), .adc_dat_i(adc_dat_i),
    .adc_vld_i(adc_vld_i), .adc_done_i(adc_done_i), .ovf(ovf), .so(sif)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] c, input logic [15:0] f, input logic [11:0] ns, input logic m);
    ctrl_word = c; conf_word = f; n_samples = ns; adc_mode = m; cmd_stb = 1'b1;
    tick();
    cmd_stb = 1'b0;
  endtask
  initial begin
    sif.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_mux", mux_cfg, 4'hF);
    chk("rst_dpot_sel", dpot_sel, 2'b11);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_busy", cmd_busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();
    send(8'h02, 16'h0005, 12'd0, 1'b0);
    chk("mux_issue_busy", cmd_busy, 1);
    chk("mux_no_start", {dac_start, dpot_start, seq_start, adc_start}, 0);
    chk("mux_not_yet", mux_cfg, 4'hF);
    tick();
    chk("mux_cfg", mux_cfg, 4'h5);
    chk("mux_done", cmd_done, 1);
    chk("mux_err", cmd_err, 0);
    tick();
    chk("mux_done_pulse", cmd_done, 0);
    chk("mux_idle", cmd_busy, 0);
    send(8'h19, 16'h0000, 12'd100, 1'b1);
    chk("adc_start", adc_start, 2'b10);
    chk("adc_n", adc_n, 100);
    chk("adc_mode_o", adc_mode_o, 1);
    tick();
    chk("adc_start_pulse", adc_start, 0);
    adc_done_i = 2'b01;
    tick();
    adc_done_i = 2'b00;
    chk("adc_ch0_ignored_done", cmd_done, 0);
    chk("adc_ch0_ignored_busy", cmd_busy, 1);
    repeat (18) tick();
    adc_done_i = 2'b10;
    tick();
    adc_done_i = 2'b00;
    chk("adc_done", cmd_done, 1);
    chk("adc_err", cmd_err, 0);
    tick();
    dpot_done = 1'b1;
    send(8'h03, 16'h02A5, 12'd0, 1'b0);
    chk("dpot_start", dpot_start, 1);
    chk("dpot_sel", dpot_sel, 2'b10);
    chk("dpot_data", dpot_data, 8'hA5);
    dpot_done = 1'b0;
    tick();
    chk("dpot_early_done", cmd_done, 0);
    chk("dpot_wait_busy", cmd_busy, 1);
    dpot_done = 1'b1;
    tick();
    dpot_done = 1'b0;
    chk("dpot_done", cmd_done, 1);
    chk("dpot_err", cmd_err, 0);
    tick();
    send(8'h24, 16'h0000, 12'd0, 1'b0);
    chk("seq_start", seq_start, 1);
    chk("seq_mode", seq_mode, 2'b10);
    tick();
    ctrl_word = 8'h02; conf_word = 16'h0000; cmd_stb = 1'b1;
    tick();
    cmd_stb = 1'b0;
    chk("busy_stb_busy", cmd_busy, 1);
    chk("busy_stb_done", cmd_done, 0);
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    chk("seq_done", cmd_done, 1);
    chk("seq_err", cmd_err, 0);
    ctrl_word = 8'h02; conf_word = 16'h0003; cmd_stb = 1'b1;
    tick();
    cmd_stb = 1'b0;
    chk("fin_stb_ignored", cmd_busy, 0);
    tick();
    chk("stb_drop_mux", mux_cfg, 4'h5);
    chk("stb_drop_idle", cmd_busy, 0);
    send(8'h29, 16'h0000, 12'd0, 1'b0);
    chk("badch_no_start", adc_start, 0);
    tick();
    chk("badch_done", cmd_done, 1);
    chk("badch_err", cmd_err, 2);
    tick();
    send(8'h07, 16'h0000, 12'd0, 1'b0);
    tick();
    chk("badop_done", cmd_done, 1);
    chk("badop_err", cmd_err, 1);
    tick();
    send(8'h01, 16'hBEEF, 12'd0, 1'b0);
    chk("dac_start", dac_start, 1);
    chk("dac_data", dac_data, 16'hBEEF);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cmd_done && n < 70000);
    chk("to_done", cmd_done, 1);
    chk("to_err", cmd_err, 3);
    chk("to_cycles", n, 65536);
    tick();
    adc_dat_i = {12'h456, 12'h123};
    adc_vld_i = 2'b11;
    tick();
    adc_vld_i = 2'b00;
    chk("rr_not_yet", sif.out_valid, 0);
    tick();
    chk("rr0_valid", sif.out_valid, 1);
    chk("rr0_data", sif.out_data, 12'h123);
    chk("rr0_ch", sif.out_ch, 0);
    tick();
    chk("rr1_data", sif.out_data, 12'h456);
    chk("rr1_ch", sif.out_ch, 1);
    tick();
    chk("rr_empty", sif.out_valid, 0);
    sif.out_ready = 1'b0;
    adc_vld_i = 2'b01;
    adc_dat_i = {12'h000, 12'h111};
    tick();
    adc_dat_i = {12'h000, 12'h222};
    tick();
    adc_dat_i = {12'h000, 12'h333};
    tick();
    adc_vld_i = 2'b00;
    chk("ovf_set", ovf, 2'b01);
    chk("stall_data", sif.out_data, 12'h111);
    tick(); tick();
    chk("stall_valid", sif.out_valid, 1);
    chk("stall_stable", sif.out_data, 12'h111);
    sif.out_ready = 1'b1;
    tick();
    chk("after_stall_data", sif.out_data, 12'h222);
    chk("after_stall_ch", sif.out_ch, 0);
    tick();
    chk("dropped_gone", sif.out_valid, 0);
    chk("ovf_sticky", ovf, 2'b01);
    send(8'h01, 16'h1234, 12'd0, 1'b0);
    tick(); tick();
    chk("pre_rst_busy", cmd_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", cmd_busy, 0);
    chk("arst_mux", mux_cfg, 4'hF);
    chk("arst_dpot_sel", dpot_sel, 2'b11);
    chk("arst_dpot_data", dpot_data, 0);
    chk("arst_dac_data", dac_data, 0);
    chk("arst_seq_mode", seq_mode, 0);
    chk("arst_adc_n", adc_n, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_valid", sif.out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h02, 16'h000A, 12'd0, 1'b0);
    tick();
    chk("post_rst_done", cmd_done, 1);
    chk("post_rst_err", cmd_err, 0);
    chk("post_rst_mux", mux_cfg, 4'hA);
    tick();
    chk("post_rst_idle", cmd_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
